// File: rtl/data_mem_responder.sv
// Word-addressed data memory answering a valid/ready load/store channel with a
// fixed number of wait states. Define DMEM_MISALIGN_CHECK_EN to flag misaligned accesses.
module data_mem_responder #(
  parameter int ADDR_BITS   = 5,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int DEPTH = 1 << ADDR_BITS;

  // Handshakes: a request transfers on a rising edge where req_valid && req_ready;
  // a response transfers on a rising edge where resp_valid && resp_ready. The
  // response payload is held until its transfer.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_next;

  logic [3:0]           cnt;
  logic                 cap_write;
  logic [ADDR_BITS-1:0] cap_idx;
  logic [31:0]          cap_wdata;
  logic [31:0]          mem [DEPTH];
  logic [31:0]          rdata_q;

  logic                 accept;
  logic                 access;
  logic                 acc_write;
  logic [ADDR_BITS-1:0] acc_idx;
  logic [31:0]          acc_wdata;
  logic                 acc_bad;

  logic                 unused_bits;
  assign unused_bits = &{1'b0, req_addr[31:ADDR_BITS+2], req_addr[1:0]};

`ifdef DMEM_MISALIGN_CHECK_EN
  logic [1:0] cap_off;
  logic [1:0] acc_off;
  logic       err_q;
  assign resp_err = err_q;
`else
  assign resp_err = 1'b0;
`endif

  assign resp_rdata = rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    access     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            access     = 1'b1;
            state_next = RESP;
          end else begin
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt == 4'd1) begin
          access     = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // With no wait states the access happens on the acceptance edge itself, so it
  // must take the live request rather than the captured copy.
  always_comb begin
    if (WAIT_CYCLES == 0) begin
      acc_write = req_write;
      acc_idx   = req_addr[ADDR_BITS+1:2];
      acc_wdata = req_wdata;
    end else begin
      acc_write = cap_write;
      acc_idx   = cap_idx;
      acc_wdata = cap_wdata;
    end
`ifdef DMEM_MISALIGN_CHECK_EN
    acc_off = (WAIT_CYCLES == 0) ? req_addr[1:0] : cap_off;
    acc_bad = (acc_off != 2'd0);
`else
    acc_bad = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 4'd0;
      cap_write <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= 32'd0;
      rdata_q   <= 32'd0;
`ifdef DMEM_MISALIGN_CHECK_EN
      cap_off   <= 2'd0;
      err_q     <= 1'b0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 32'd0;
      end
    end else begin
      if (accept) begin
        cnt       <= 4'(WAIT_CYCLES);
        cap_write <= req_write;
        cap_idx   <= req_addr[ADDR_BITS+1:2];
        cap_wdata <= req_wdata;
`ifdef DMEM_MISALIGN_CHECK_EN
        cap_off   <= req_addr[1:0];
`endif
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        if (acc_write && !acc_bad) begin
          mem[acc_idx] <= acc_wdata;
        end
        rdata_q <= (acc_write || acc_bad) ? 32'd0 : mem[acc_idx];
`ifdef DMEM_MISALIGN_CHECK_EN
        err_q   <= acc_bad;
`endif
      end
    end
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Word-addressed data memory for the MIPS core, acting as the responder end of a valid/ready load/store request channel.
- Replaces the zero-latency data memory when the datapath runs with a multicycle memory stage.
- Accepts one request at a time, inserts a configurable number of wait states, then returns a response that is held until the core consumes it.

Parameters:
- ADDR_BITS, 5, word-index width; storage is 2^ADDR_BITS 32-bit words (default 32 words).
- WAIT_CYCLES, 2, wait states between request acceptance and the memory access; legal range 0..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core presents a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address; word index = req_addr[ADDR_BITS+1:2].
- req_wdata  in  32  store data.
- req_ready  out  1  responder can accept a request this cycle.
- resp_valid  out  1  response available.
- resp_ready  in  1  core consumes the response.
- resp_rdata  out  32  load data; 0 for stores.
- resp_err  out  1  misaligned-access flag (see Optional Feature).

Behaviour:
- Reset (rst=1 at a clock edge):
  - State becomes IDLE.
  - All storage words are cleared to 0.
  - Outputs: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - Any in-flight request is aborted; an uncommitted store is discarded.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, capture write flag, word index, wdata and addr[1:0].
  - Load the wait counter with WAIT_CYCLES.
  - If WAIT_CYCLES=0, go directly to RESP; otherwise go to BUSY.
- BUSY:
  - req_ready=0; the counter decrements each cycle.
  - On the cycle the counter reaches 1, perform the access and go to RESP.
- Access, on entry to RESP:
  - Store: write wdata to the indexed word; resp_rdata=0.
  - Load: resp_rdata = indexed word.
- Latency: resp_valid rises exactly WAIT_CYCLES+1 cycles after the acceptance edge.
- RESP:
  - resp_valid=1, req_ready=0.
  - resp_rdata and resp_err are held stable until resp_valid&&resp_ready.
  - On that handshake, go to IDLE: resp_valid=0 and req_ready=1 on the next cycle, so there is at most one request in flight.
  - Minimum spacing between acceptances is WAIT_CYCLES+2 cycles.
- Requests presented while req_ready=0 are ignored and have no side effects; the core must hold them.
- Address bits above ADDR_BITS+1 are ignored, so addresses alias modulo 2^(ADDR_BITS+2) bytes.
- Store followed by load to the same word returns the stored value; there is no forwarding hazard because storage is updated before the next acceptance.
- rst asserted in the same cycle as req_valid: reset wins and the request is not accepted.

Optional Feature:
- Macro name: DMEM_MISALIGN_CHECK_EN.
- Defined:
  - An accepted request with addr[1:0]!=0 skips storage entirely; no write occurs.
  - Its response has resp_err=1 and resp_rdata=0.
  - Timing is identical to a normal access.
- Undefined:
  - addr[1:0] is ignored and resp_err is tied to 0.

Test Plan:
- Reset, then load from 0x0000_0010 with WAIT_CYCLES=2 -> req_ready=0 for 3 cycles; resp_valid at acceptance+3; resp_rdata=0x0000_0000.
- Store 0xDEADBEEF to 0x0000_0008, handshake, then load 0x0000_0008 -> load response resp_rdata=0xDEADBEEF; store response resp_rdata=0.
- Aliasing: store 0x12345678 to 0x0000_0084 (ADDR_BITS=5), load 0x0000_0004 -> 0x12345678.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_rdata stable; req_valid pulses during that window are not accepted; one cycle after resp_ready=1, req_ready=1.
- Reset mid-BUSY: store 0xA5A5A5A5 to 0x0000_000C, assert rst one cycle after acceptance, then load 0x0000_000C -> 0x00000000.
- With DMEM_MISALIGN_CHECK_EN defined, store 0xFFFFFFFF to 0x0000_0002 -> resp_err=1; a subsequent load of 0x0000_0000 returns 0; WAIT_CYCLES=0 build gives resp_valid at acceptance+1.
